// File: rtl/rob_commit_pkg.sv
// Shared reorder-buffer types and sizes; the decoder and regfile use the same TAG_FREE.
package rob_commit_pkg;

  localparam int DEPTH  = 8;
  localparam int IDX_W  = 3;
  localparam int TAG_W  = 4;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = IDX_W + 1;

  // Tag value meaning "no producer"; one past the last entry index.
  localparam logic [TAG_W-1:0] TAG_FREE = TAG_W'(DEPTH);

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [REG_W-1:0]  dest_reg;
    logic [DATA_W-1:0] data;
  } rob_entry_t;

  // True when the tag names a real entry rather than TAG_FREE.
  function automatic logic tag_in_range(input logic [TAG_W-1:0] tag);
    return (tag < TAG_FREE);
  endfunction

endpackage

// File: rtl/rob_commit_query.sv
// Operand lookup into the ROB with same-cycle CDB bypass.
module rob_query_port
  import rob_commit_pkg::*;
(
  input  logic [TAG_W-1:0]             q_tag,
  input  logic [DEPTH-1:0]             ent_valid,
  input  logic [DEPTH-1:0]             ent_done,
  input  logic [DEPTH-1:0][DATA_W-1:0] ent_data,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [DATA_W-1:0]            cdb_data,
  output logic                         q_ready,
  output logic [DATA_W-1:0]            q_data
);

  logic [IDX_W-1:0] q_idx_s;

  // Resolve the queried tag: a matching broadcast wins over stored data; TAG_FREE and empty slots read as not ready.
  always_comb begin
    q_ready = 1'b0;
    q_data  = {DATA_W{1'b0}};
    q_idx_s = q_tag[IDX_W-1:0];
    if (tag_in_range(q_tag) && ent_valid[q_idx_s]) begin
      if (cdb_valid && (cdb_tag == q_tag)) begin
        q_ready = 1'b1;
        q_data  = cdb_data;
      end else if (ent_done[q_idx_s]) begin
        q_ready = 1'b1;
        q_data  = ent_data[q_idx_s];
      end else begin
        q_ready = 1'b0;
        q_data  = {DATA_W{1'b0}};
      end
    end else begin
      q_ready = 1'b0;
      q_data  = {DATA_W{1'b0}};
    end
  end

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer: in-order allocate, out-of-order CDB completion, in-order commit to the regfile.
module rob_commit
  import rob_commit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_reg,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              commit_en,
  output logic [REG_W-1:0]  commit_reg,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W-1:0]  commit_tag,
  input  logic [TAG_W-1:0]  q1_tag,
  input  logic [TAG_W-1:0]  q2_tag,
  output logic              q1_ready,
  output logic              q2_ready,
  output logic [DATA_W-1:0] q1_data,
  output logic [DATA_W-1:0] q2_data,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  rob_entry_t [DEPTH-1:0]       entries_q, entries_d;
  logic [IDX_W-1:0]             head_q, head_d;
  logic [IDX_W-1:0]             tail_q, tail_d;
  logic [CNT_W-1:0]             count_q, count_d;
  rob_entry_t                   head_entry_s;
  rob_entry_t                   slot_s;
  logic                         commit_en_s;
  logic                         alloc_ready_s;
  logic                         alloc_fire_s;
  logic                         cdb_hit_s;
  logic [IDX_W-1:0]             cdb_idx_s;
  logic [DEPTH-1:0]             ent_valid_s;
  logic [DEPTH-1:0]             ent_done_s;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data_s;

  // Handshake decisions and pointer/occupancy updates; a full buffer does not credit a same-cycle commit.
  always_comb begin
    head_entry_s  = entries_q[head_q];
    commit_en_s   = head_entry_s.valid && head_entry_s.done;
    alloc_ready_s = (count_q != CNT_W'(DEPTH));
    alloc_fire_s  = alloc_valid && alloc_ready_s;
    cdb_idx_s     = cdb_tag[IDX_W-1:0];
    cdb_hit_s     = cdb_valid && tag_in_range(cdb_tag) && entries_q[cdb_idx_s].valid;
    head_d        = commit_en_s  ? (head_q + IDX_W'(1)) : head_q;
    tail_d        = alloc_fire_s ? (tail_q + IDX_W'(1)) : tail_q;
    count_d       = count_q + CNT_W'(alloc_fire_s) - CNT_W'(commit_en_s);
  end

  // Per-slot next state; commit clears the head, CDB marks a valid entry done, alloc fills the tail.
  always_comb begin
    entries_d = entries_q;
    slot_s    = entries_q[0];
    for (int i = 0; i < DEPTH; i++) begin
      slot_s = entries_q[i];
      if (commit_en_s && (head_q == IDX_W'(i))) begin
        slot_s.valid = 1'b0;
        slot_s.done  = 1'b0;
      end else if (cdb_hit_s && (cdb_idx_s == IDX_W'(i))) begin
        slot_s.done = 1'b1;
        slot_s.data = cdb_data;
      end else if (alloc_fire_s && (tail_q == IDX_W'(i))) begin
        slot_s.valid    = 1'b1;
        slot_s.done     = 1'b0;
        slot_s.dest_reg = alloc_reg;
        slot_s.data     = {DATA_W{1'b0}};
      end else begin
        slot_s = entries_q[i];
      end
      entries_d[i] = slot_s;
    end
  end

  // State registers; reset discards every in-flight entry and wins over alloc, CDB and commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q <= {($bits(entries_q)){1'b0}};
      head_q    <= {IDX_W{1'b0}};
      tail_q    <= {IDX_W{1'b0}};
      count_q   <= {CNT_W{1'b0}};
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Commit port mirrors the head entry only while it retires, otherwise reads as zero.
  always_comb begin
    if (commit_en_s) begin
      commit_reg  = head_entry_s.dest_reg;
      commit_data = head_entry_s.data;
      commit_tag  = {1'b0, head_q};
    end else begin
      commit_reg  = {REG_W{1'b0}};
      commit_data = {DATA_W{1'b0}};
      commit_tag  = {TAG_W{1'b0}};
    end
  end

  // Flatten entry fields for the query ports so they see only what they use.
  always_comb begin
    ent_valid_s = {DEPTH{1'b0}};
    ent_done_s  = {DEPTH{1'b0}};
    ent_data_s  = {($bits(ent_data_s)){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid_s[i] = entries_q[i].valid;
      ent_done_s[i]  = entries_q[i].done;
      ent_data_s[i]  = entries_q[i].data;
    end
  end

  assign commit_en   = commit_en_s;
  assign alloc_ready = alloc_ready_s;
  assign alloc_tag   = {1'b0, tail_q};
  assign count       = count_q;
  assign empty       = (count_q == {CNT_W{1'b0}});

  rob_query_port u_q1 (
    .q_tag     (q1_tag),
    .ent_valid (ent_valid_s),
    .ent_done  (ent_done_s),
    .ent_data  (ent_data_s),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .q_ready   (q1_ready),
    .q_data    (q1_data)
  );

  rob_query_port u_q2 (
    .q_tag     (q2_tag),
    .ent_valid (ent_valid_s),
    .ent_done  (ent_done_s),
    .ent_data  (ent_data_s),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .q_ready   (q2_ready),
    .q_data    (q2_data)
  );

endmodule

// File: tb/tb_rob_commit.sv
// Scenario bench for rob_commit: scoreboard of expected commits plus per-scenario inline checks.
module tb_rob_commit;

  logic        clk, rst;
  logic        alloc_valid;
  logic [4:0]  alloc_reg;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        commit_en;
  logic [4:0]  commit_reg;
  logic [31:0] commit_data;
  logic [3:0]  commit_tag;
  logic [3:0]  q1_tag, q2_tag;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_data, q2_data;
  logic        empty;
  logic [3:0]  count;

  rob_commit dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_reg(alloc_reg), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .commit_en(commit_en), .commit_reg(commit_reg), .commit_data(commit_data), .commit_tag(commit_tag),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_data(q1_data), .q2_data(q2_data), .empty(empty), .count(count)
  );

  typedef struct packed {
    logic [4:0] rd;
    logic [3:0] tag;
  } sb_t;

  sb_t         exp_q[$];
  sb_t         mon_item;
  logic        exp_valid [8];
  logic [31:0] exp_data [8];
  int          m_tail;
  int          checks;
  int          failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every retirement must match the oldest outstanding allocation.
  always @(negedge clk) begin
    if (!rst && commit_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_commit got tag=%0d reg=%0d, expected no commit", commit_tag, commit_reg);
      end else begin
        mon_item = exp_q.pop_front();
        if (commit_reg !== mon_item.rd || commit_tag !== mon_item.tag ||
            commit_data !== exp_data[mon_item.tag[2:0]]) begin
          failures++;
          $display("FAIL sb_commit got reg=%0d tag=%0d data=%h expected reg=%0d tag=%0d data=%h",
                   commit_reg, commit_tag, commit_data, mon_item.rd, mon_item.tag, exp_data[mon_item.tag[2:0]]);
        end
        exp_valid[mon_item.tag[2:0]] = 1'b0;
      end
    end
  end

  task step;
    @(posedge clk);
    #1;
    alloc_valid = 1'b0;
    cdb_valid   = 1'b0;
  endtask

  task flush_model;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      exp_valid[i] = 1'b0;
      exp_data[i]  = 32'h0;
    end
    m_tail = 0;
  endtask

  task drive_alloc(input logic [4:0] r);
    sb_t item;
    alloc_valid = 1'b1;
    alloc_reg   = r;
    item.rd     = r;
    item.tag    = m_tail[3:0];
    exp_q.push_back(item);
    exp_valid[m_tail] = 1'b1;
    m_tail = (m_tail + 1) % 8;
  endtask

  task drive_cdb(input logic [3:0] t, input logic [31:0] d);
    cdb_valid = 1'b1;
    cdb_tag   = t;
    cdb_data  = d;
    if (t < 4'd8) begin
      if (exp_valid[t[2:0]]) exp_data[t[2:0]] = d;
    end
  endtask

  task do_reset;
    rst = 1'b1;
    step();
    rst = 1'b0;
    flush_model();
  endtask

  task test_reset;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    flush_model();
    q1_tag = 4'd0;
    q2_tag = 4'd8;
    #2;
    checks++; if (alloc_ready !== 1'b1) begin failures++; $display("FAIL reset_alloc_ready got=%b exp=1", alloc_ready); end
    checks++; if (alloc_tag !== 4'd0) begin failures++; $display("FAIL reset_alloc_tag got=%0d exp=0", alloc_tag); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (commit_en !== 1'b0) begin failures++; $display("FAIL reset_commit_en got=%b exp=0", commit_en); end
    checks++; if ({commit_reg, commit_data, commit_tag} !== 41'h0) begin failures++; $display("FAIL reset_commit_fields got=%0d/%h/%0d exp=0", commit_reg, commit_data, commit_tag); end
    checks++; if (q1_ready !== 1'b0 || q1_data !== 32'h0) begin failures++; $display("FAIL reset_q1 got=%b/%h exp=0/0", q1_ready, q1_data); end
    checks++; if (q2_ready !== 1'b0 || q2_data !== 32'h0) begin failures++; $display("FAIL reset_q2 got=%b/%h exp=0/0", q2_ready, q2_data); end
  endtask

  task test_out_of_order;
    drive_alloc(5'd5);
    step();
    drive_alloc(5'd6);
    #2;
    checks++; if (alloc_tag !== 4'd1) begin failures++; $display("FAIL ooo_alloc_tag got=%0d exp=1", alloc_tag); end
    step();
    drive_cdb(4'd1, 32'h0000BEEF);
    step();
    drive_cdb(4'd0, 32'h00001234);
    #2;
    checks++; if (commit_en !== 1'b0) begin failures++; $display("FAIL ooo_no_early_commit got=%b exp=0", commit_en); end
    step();
    #2;
    checks++; if (commit_en !== 1'b1 || commit_tag !== 4'd0) begin failures++; $display("FAIL ooo_first_commit got en=%b tag=%0d exp en=1 tag=0", commit_en, commit_tag); end
    step();
    #2;
    checks++; if (commit_en !== 1'b1 || commit_tag !== 4'd1 || commit_data !== 32'h0000BEEF) begin failures++; $display("FAIL ooo_second_commit got en=%b tag=%0d data=%h exp en=1 tag=1 data=0000beef", commit_en, commit_tag, commit_data); end
    step();
    #2;
    checks++; if (empty !== 1'b1 || commit_en !== 1'b0) begin failures++; $display("FAIL ooo_drained got empty=%b en=%b exp 1/0", empty, commit_en); end
  endtask

  task test_full;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive_alloc(5'(10 + i));
      step();
    end
    #2;
    checks++; if (count !== 4'd8 || alloc_ready !== 1'b0) begin failures++; $display("FAIL full_state got count=%0d ready=%b exp 8/0", count, alloc_ready); end
    checks++; if (alloc_tag !== 4'd0) begin failures++; $display("FAIL full_tail_wrap got=%0d exp=0", alloc_tag); end
    alloc_valid = 1'b1;
    alloc_reg   = 5'd31;
    step();
    #2;
    checks++; if (count !== 4'd8 || alloc_tag !== 4'd0) begin failures++; $display("FAIL full_extra_ignored got count=%0d tag=%0d exp 8/0", count, alloc_tag); end
    drive_cdb(4'd0, 32'h00000100);
    step();
    alloc_valid = 1'b1;
    alloc_reg   = 5'd20;
    #2;
    checks++; if (commit_en !== 1'b1 || alloc_ready !== 1'b0) begin failures++; $display("FAIL full_commit_no_credit got en=%b ready=%b exp 1/0", commit_en, alloc_ready); end
    step();
    #2;
    checks++; if (alloc_ready !== 1'b1 || count !== 4'd7 || alloc_tag !== 4'd0) begin failures++; $display("FAIL full_after_commit got ready=%b count=%0d tag=%0d exp 1/7/0", alloc_ready, count, alloc_tag); end
    drive_alloc(5'd21);
    step();
    #2;
    checks++; if (count !== 4'd8 || alloc_tag !== 4'd1) begin failures++; $display("FAIL full_refill got count=%0d tag=%0d exp 8/1", count, alloc_tag); end
  endtask

  task test_bypass;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_alloc(5'(1 + i));
      step();
    end
    q1_tag = 4'd3;
    q2_tag = 4'd2;
    drive_cdb(4'd3, 32'h000000AA);
    #2;
    checks++; if (q1_ready !== 1'b1 || q1_data !== 32'h000000AA) begin failures++; $display("FAIL bypass_same_cycle got=%b/%h exp=1/000000aa", q1_ready, q1_data); end
    checks++; if (q2_ready !== 1'b0 || q2_data !== 32'h0) begin failures++; $display("FAIL bypass_pending_q2 got=%b/%h exp=0/0", q2_ready, q2_data); end
    step();
    #2;
    checks++; if (q1_ready !== 1'b1 || q1_data !== 32'h000000AA) begin failures++; $display("FAIL bypass_stored got=%b/%h exp=1/000000aa", q1_ready, q1_data); end
    checks++; if (commit_en !== 1'b0) begin failures++; $display("FAIL bypass_no_commit got=%b exp=0", commit_en); end
    drive_cdb(4'd0, 32'h00000010);
    step();
    drive_cdb(4'd1, 32'h00000011);
    step();
    drive_cdb(4'd2, 32'h00000012);
    step();
    step();
    step();
    step();
    #2;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL bypass_drained got empty=%b exp=1", empty); end
    q1_tag = 4'd8;
    q2_tag = 4'd8;
  endtask

  task test_ignored_cdb;
    q2_tag = 4'd8;
    drive_cdb(4'd8, 32'h0000DEAD);
    #2;
    checks++; if (q2_ready !== 1'b0 || q2_data !== 32'h0) begin failures++; $display("FAIL ign_query_free got=%b/%h exp=0/0", q2_ready, q2_data); end
    step();
    drive_cdb(4'd5, 32'h00005555);
    step();
    #2;
    checks++; if (commit_en !== 1'b0 || empty !== 1'b1 || count !== 4'd0) begin failures++; $display("FAIL ign_no_change got en=%b empty=%b count=%0d exp 0/1/0", commit_en, empty, count); end
    drive_alloc(5'd7);
    step();
    drive_alloc(5'd0);
    step();
    drive_cdb(4'd4, 32'h00000044);
    step();
    #2;
    checks++; if (commit_en !== 1'b1 || commit_tag !== 4'd4) begin failures++; $display("FAIL ign_head_commit got en=%b tag=%0d exp 1/4", commit_en, commit_tag); end
    step();
    #2;
    checks++; if (commit_en !== 1'b0 || count !== 4'd1) begin failures++; $display("FAIL ign_stray_not_done got en=%b count=%0d exp 0/1", commit_en, count); end
    drive_cdb(4'd5, 32'h00000055);
    step();
    step();
    #2;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ign_drained got empty=%b exp=1", empty); end
  endtask

  task test_back_to_back;
    int prev_tag;
    prev_tag = 0;
    for (int k = 0; k < 7; k++) begin
      if (k >= 1) drive_cdb(4'(prev_tag), 32'hC0DE0000 + 32'(k));
      prev_tag = m_tail;
      if (k < 6) drive_alloc(5'(20 + k));
      #2;
      if (k >= 2) begin
        checks++; if (commit_en !== 1'b1 || count !== 4'd2) begin failures++; $display("FAIL b2b_cycle%0d got en=%b count=%0d exp 1/2", k, commit_en, count); end
      end
      step();
    end
    step();
    #2;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL b2b_drained got empty=%b exp=1", empty); end
  endtask

  task test_reset_midflight;
    // Tail sits at 4 here, so the five entries take tags 4,5,6,7,0.
    for (int i = 0; i < 5; i++) begin
      drive_alloc(5'(1 + i));
      step();
    end
    drive_cdb(4'd0, 32'h00000077);
    step();
    rst         = 1'b1;
    cdb_valid   = 1'b1;
    cdb_tag     = 4'd4;
    cdb_data    = 32'h00000099;
    alloc_valid = 1'b1;
    alloc_reg   = 5'd3;
    step();
    rst = 1'b0;
    flush_model();
    #2;
    checks++; if (count !== 4'd0 || empty !== 1'b1 || commit_en !== 1'b0) begin failures++; $display("FAIL rst_mid_state got count=%0d empty=%b en=%b exp 0/1/0", count, empty, commit_en); end
    checks++; if (alloc_tag !== 4'd0 || alloc_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_alloc got tag=%0d ready=%b exp 0/1", alloc_tag, alloc_ready); end
    q1_tag = 4'd5;
    drive_cdb(4'd5, 32'h00000088);
    #2;
    checks++; if (q1_ready !== 1'b0 || q1_data !== 32'h0) begin failures++; $display("FAIL rst_mid_old_query got=%b/%h exp=0/0", q1_ready, q1_data); end
    step();
    #2;
    checks++; if (commit_en !== 1'b0 || count !== 4'd0) begin failures++; $display("FAIL rst_mid_old_cdb got en=%b count=%0d exp 0/0", commit_en, count); end
    drive_alloc(5'd9);
    step();
    #2;
    checks++; if (commit_en !== 1'b0) begin failures++; $display("FAIL rst_mid_stale_done got en=%b exp=0", commit_en); end
    drive_cdb(4'd0, 32'h00000090);
    step();
    #2;
    checks++; if (commit_en !== 1'b1) begin failures++; $display("FAIL rst_mid_new_commit got en=%b exp=1", commit_en); end
    step();
    #2;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_mid_drained got empty=%b exp=1", empty); end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    alloc_valid = 1'b0;
    alloc_reg   = 5'd0;
    cdb_valid   = 1'b0;
    cdb_tag     = 4'd0;
    cdb_data    = 32'h0;
    q1_tag      = 4'd8;
    q2_tag      = 4'd8;
    flush_model();
    test_reset();
    test_out_of_order();
    test_full();
    test_bypass();
    test_ignored_cdb();
    test_back_to_back();
    test_reset_midflight();
    step();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d pending exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rob_commit.md
# rob_commit

Reorder buffer for the out-of-order core: allocates one entry per decoded instruction in program order, collects results from the common data bus (CDB), and retires completed head entries in order. It sits directly upstream of the register file. Its commit port drives the register file write port (enable, register name, data, tag). Its allocation tag is what the decoder writes into the register file tag table for the destination register.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two.
- IDX_W, 3, log2(DEPTH).
- TAG_W, 4, IDX_W+1; tag values 0..DEPTH-1 name entries, TAG_FREE = DEPTH means "no producer".
- REG_W, 5, architectural register index width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- alloc_valid  in  1  decoder requests an entry.
- alloc_reg  in  REG_W  destination register of the new entry (0 allowed).
- alloc_ready  out  1  entry available (not full).
- alloc_tag  out  TAG_W  tag the next allocation receives (= tail index, MSB 0).
- cdb_valid  in  1  result broadcast valid.
- cdb_tag  in  TAG_W  producing entry tag.
- cdb_data  in  DATA_W  result value.
- commit_en  out  1  head retires this cycle (to regfile write enable).
- commit_reg  out  REG_W  head destination register.
- commit_data  out  DATA_W  head result.
- commit_tag  out  TAG_W  head tag (the regfile clears the register's tag only if it matches).
- q1_tag, q2_tag  in  TAG_W  operand query tags.
- q1_ready, q2_ready  out  1  queried entry has its result.
- q1_data, q2_data  out  DATA_W  queried result; 0 when not ready.
- empty  out  1  no valid entries.
- count  out  IDX_W+1  number of valid entries.

## Operation
- Per-entry state: valid, done, reg, data. head/tail pointers are IDX_W bits and wrap modulo DEPTH. count disambiguates full from empty.
- Allocate: when alloc_valid && alloc_ready, the tail entry gets valid=1, done=0, reg=alloc_reg, and tail advances. When alloc_valid is high while full, the request is ignored and no state changes.
- Complete: when cdb_valid is high, cdb_tag < DEPTH, and that entry is valid, set done=1 and data=cdb_data. A CDB hit on an invalid entry, or cdb_tag == TAG_FREE, is ignored. A repeat completion overwrites data.
- Commit: commit_en = head.valid && head.done, combinational. On that edge the head entry is cleared (valid=0, done=0) and head advances. Entries with reg 0 still commit; the regfile discards them.
- count_next = count + alloc_fire − commit_en.
- Query: q_ready=1 and q_data=entry.data when the entry is valid and done. Same-cycle CDB bypass: if cdb_valid && cdb_tag == q_tag and the entry is valid, then q_ready=1 and q_data=cdb_data. TAG_FREE or an invalid entry gives q_ready=0, q_data=0.

## Timing
- Reset values: head=tail=0, count=0, all valid/done cleared. Outputs: alloc_ready=1, alloc_tag=0, commit_en=0, commit_reg=0, commit_data=0, commit_tag=0, empty=1, q*_ready=0, q*_data=0.
- rst mid-operation discards all in-flight entries on the same edge, and has priority over alloc, CDB and commit.
- alloc_ready = (count != DEPTH). It does not credit a same-cycle commit, so a full buffer accepts the next allocation one cycle after a commit.
- CDB to commit latency is 1 cycle. A completion at edge N for the head entry gives commit_en high during cycle N+1.
- Throughput: one allocation, one completion and one commit per cycle, all in the same cycle.
- Allocation into a slot while that slot commits is impossible, because a full buffer blocks allocation.
- Commit outputs are combinational from head state. commit_reg, commit_data and commit_tag show the head entry's fields when commit_en=1 and are 0 otherwise.

## Structure
- Shared package: TAG_W, REG_W, DATA_W, TAG_FREE, DEPTH, and the rob_entry struct {valid, done, reg, data}. The regfile and decoder use the same TAG_FREE.
- One sub-module, rob_query_port: combinational lookup plus CDB bypass, instantiated twice.

## Test plan
- Reset, then idle → alloc_ready=1, alloc_tag=0, empty=1, commit_en=0.
- Allocate r5, r6 (tags 0, 1). CDB tag 1 =0xBEEF, then tag 0 =0x1234 → commit r5/0x1234/tag0, then r6/0xBEEF/tag1 on consecutive cycles; in-order retirement despite out-of-order completion.
- Fill 8 entries → alloc_ready=0, count=8. Extra alloc is ignored. Complete head, commit; alloc_ready=1 the next cycle. Tail wraps and alloc_tag returns to 0.
- Query q1_tag=3 with pending entry 3 and cdb_valid, tag 3, 0xAA in the same cycle → q1_ready=1, q1_data=0xAA; next cycle still ready from stored data.
- CDB with tag 8 (TAG_FREE) and with an unallocated tag → no state change, commit_en stays 0.
- Assert rst with 5 entries in flight → next cycle count=0, empty=1, commit_en=0, and a later CDB to an old tag is ignored.
